// File: rtl/vid_pkg.sv
// Shared constants, state encoding and helpers for the vertex-ID SRAM writer.
package vid_pkg;

    localparam int VID_BW     = 16;
    localparam int Q          = 16;
    localparam int ADDR_SPACE = 5;
    localparam logic [VID_BW-1:0] PAD_VID = {VID_BW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // A single-lane build still needs a 1-bit counter to keep the ports legal.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    localparam int LANE_W = lane_idx_w(Q);

endpackage

// File: rtl/vid_lane_pack.sv
// Q-lane staging register: loads one vertex ID per handshake and presents the
// word as it will look after this cycle's load, so the writer can latch it directly.
module vid_lane_pack
    import vid_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  preset_i,
    input  logic                  load_i,
    input  logic [VID_BW-1:0]     vid_i,
    output logic                  last_lane_o,
    output logic [VID_BW*Q-1:0]   word_next_o
);

    logic [Q-1:0][VID_BW-1:0] lanes_q, lanes_d;
    logic [LANE_W-1:0]        cnt_q, cnt_d;

    always_comb begin
        lanes_d = lanes_q;
        cnt_d   = cnt_q;
        if (preset_i) begin
            lanes_d = {Q{PAD_VID}};
            cnt_d   = '0;
        end else if (load_i) begin
            lanes_d[cnt_q] = vid_i;
            cnt_d          = cnt_q + LANE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q <= {Q{PAD_VID}};
            cnt_q   <= '0;
        end else begin
            lanes_q <= lanes_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last_lane_o = (cnt_q == LANE_W'(Q - 1));
    assign word_next_o = lanes_d;

endmodule

// File: rtl/vid_sram_writer.sv
// Packs a serial vertex-ID stream into Q-lane words and writes them to the
// vertex-ID SRAM at sequential addresses, reporting batch count, done and overflow.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   FILL  | accepting IDs into the lane register
//   WRITE | one-cycle active-low write of the packed word
//   DONE  | session finished (last seen or SRAM full), waiting for start
module vid_sram_writer
    import vid_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [VID_BW-1:0]     in_vid,
    input  logic                  in_last,
    output logic                  sram_wsb,
    output logic [ADDR_SPACE-1:0] sram_waddr,
    output logic [VID_BW*Q-1:0]   sram_wdata,
    output logic [ADDR_SPACE:0]   batch_cnt,
    output logic                  done,
    output logic                  overflow
);

    state_e                  state_q;
    logic                    in_ready_q;
    logic                    wsb_q;
    logic [ADDR_SPACE-1:0]   waddr_q;
    logic [VID_BW*Q-1:0]     wdata_q;
    logic [ADDR_SPACE:0]     batch_q;
    logic                    done_q;
    logic                    ovf_q;
    logic                    last_q;

    logic                    hs;
    logic                    preset;
    logic                    last_lane;
    logic [VID_BW*Q-1:0]     word_next;

    assign hs     = in_valid && in_ready_q && (state_q == FILL);
    assign preset = (((state_q == IDLE) || (state_q == DONE)) && start)
                    || (state_q == WRITE);

    vid_lane_pack u_lane_pack (
        .clk         (clk),
        .rst_n       (rst_n),
        .preset_i    (preset),
        .load_i      (hs),
        .vid_i       (in_vid),
        .last_lane_o (last_lane),
        .word_next_o (word_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            wsb_q      <= 1'b1;
            waddr_q    <= '0;
            wdata_q    <= {Q{PAD_VID}};
            batch_q    <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= FILL;
                        in_ready_q <= 1'b1;
                        waddr_q    <= '0;
                        batch_q    <= '0;
                        done_q     <= 1'b0;
                        ovf_q      <= 1'b0;
                        last_q     <= 1'b0;
                    end
                end
                FILL: begin
                    if (hs && (in_last || last_lane)) begin
                        state_q    <= WRITE;
                        in_ready_q <= 1'b0;
                        wsb_q      <= 1'b0;
                        waddr_q    <= batch_q[ADDR_SPACE-1:0];
                        wdata_q    <= word_next;
                        last_q     <= in_last;
                    end
                end
                WRITE: begin
                    wsb_q   <= 1'b1;
                    batch_q <= batch_q + (ADDR_SPACE+1)'(1);
                    if (last_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (waddr_q == '1) begin
                        // Last address used without in_last: stop rather than wrap.
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        ovf_q   <= 1'b1;
                    end else begin
                        state_q    <= FILL;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                    wsb_q      <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign sram_wsb   = wsb_q;
    assign sram_waddr = waddr_q;
    assign sram_wdata = wdata_q;
    assign batch_cnt  = batch_q;
    assign done       = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_vid_sram_writer.sv
// Directed and randomized bench for vid_sram_writer; SRAM writes are captured
// and compared against words computed from the stimulus list.
module tb_vid_sram_writer;
    import vid_pkg::*;

    localparam int WW = VID_BW * Q;
    localparam int NW = 1 << ADDR_SPACE;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic [VID_BW-1:0]     in_vid;
    logic                  in_last;
    logic                  sram_wsb;
    logic [ADDR_SPACE-1:0] sram_waddr;
    logic [WW-1:0]         sram_wdata;
    logic [ADDR_SPACE:0]   batch_cnt;
    logic                  done;
    logic                  overflow;

    vid_sram_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vid     (in_vid),
        .in_last    (in_last),
        .sram_wsb   (sram_wsb),
        .sram_waddr (sram_waddr),
        .sram_wdata (sram_wdata),
        .batch_cnt  (batch_cnt),
        .done       (done),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [VID_BW-1:0]     stim[$];
    logic [ADDR_SPACE-1:0] cap_addr[$];
    logic [WW-1:0]         cap_data[$];

    // Stands in for the SRAM: one captured entry per low-strobe cycle.
    always @(negedge clk) begin
        if (rst_n && !sram_wsb) begin
            cap_addr.push_back(sram_waddr);
            cap_data.push_back(sram_wdata);
        end
    end

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] model_word(input int w);
        logic [WW-1:0] word;
        word = {Q{PAD_VID}};
        for (int l = 0; l < Q; l++) begin
            if (w * Q + l < stim.size())
                word[l*VID_BW +: VID_BW] = stim[w*Q + l];
        end
        return word;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_stream(input bit use_last, input bit gaps, input bit noise);
        int idx;
        int cyc;
        int n;
        idx = 0;
        cyc = 0;
        n   = stim.size();
        while (idx < n && cyc < n * 8 + 64) begin
            @(negedge clk);
            cyc++;
            in_valid = !(gaps && ($urandom_range(0, 3) == 0));
            in_vid   = in_valid ? stim[idx] : VID_BW'($urandom);
            in_last  = in_valid ? (use_last && (idx == n - 1)) : 1'($urandom_range(0, 1));
            start    = noise && !done && ($urandom_range(0, 7) == 0);
            if (in_valid && in_ready) idx++;
        end
        check("ids_accepted", WW'(idx), WW'(n));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_session(input bit use_last, input bit gaps, input bit noise);
        int nw;
        int w;
        cap_addr.delete();
        cap_data.delete();
        pulse_start();
        drive_stream(use_last, gaps, noise);
        w = 0;
        while (!done && w < 64) begin
            @(negedge clk);
            w++;
        end
        check("done", WW'(done), WW'(1));
        nw = (stim.size() + Q - 1) / Q;
        if (nw > NW) nw = NW;
        check("write_count", WW'(cap_addr.size()), WW'(nw));
        for (int i = 0; i < nw && i < cap_addr.size(); i++) begin
            check($sformatf("waddr[%0d]", i), WW'(cap_addr[i]), WW'(i));
            check($sformatf("wdata[%0d]", i), cap_data[i], model_word(i));
        end
        check("batch_cnt", WW'(batch_cnt), WW'(nw));
        check("overflow", WW'(overflow), WW'(!use_last));
        in_valid = 1'b1;
        in_vid   = 16'h1234;
        repeat (3) begin
            @(negedge clk);
            check("ready_low_after_done", WW'(in_ready), WW'(0));
        end
        in_valid = 1'b0;
        check("no_extra_write", WW'(cap_addr.size()), WW'(nw));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, WW'(in_ready), WW'(0));
        check({tag, "_wsb"}, WW'(sram_wsb), WW'(1));
        check({tag, "_waddr"}, WW'(sram_waddr), WW'(0));
        check({tag, "_wdata"}, sram_wdata, {Q{PAD_VID}});
        check({tag, "_batch"}, WW'(batch_cnt), WW'(0));
        check({tag, "_done"}, WW'(done), WW'(0));
        check({tag, "_ovf"}, WW'(overflow), WW'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_vid   = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("idle");

        // 16 IDs with last on the final lane
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(VID_BW'(i));
        run_session(1'b1, 1'b0, 1'b0);

        // 20 IDs, partial second word, first without then with gaps/start noise
        stim.delete();
        for (int i = 16; i < 36; i++) stim.push_back(VID_BW'(i));
        run_session(1'b1, 1'b0, 1'b0);
        run_session(1'b1, 1'b1, 1'b1);

        // random lengths, gaps and ignored start pulses
        repeat (4) begin
            stim.delete();
            for (int i = 0; i < $urandom_range(1, 80); i++) stim.push_back(VID_BW'($urandom));
            run_session(1'b1, 1'b1, 1'b1);
        end

        // fill the SRAM without in_last -> overflow
        stim.delete();
        for (int i = 0; i < NW * Q; i++) stim.push_back(VID_BW'($urandom));
        run_session(1'b0, 1'b0, 1'b0);

        // single ID
        stim.delete();
        stim.push_back(16'h00A5);
        run_session(1'b1, 1'b0, 1'b0);

        // in_last on the very last lane of the last address -> no overflow
        stim.delete();
        for (int i = 0; i < NW * Q; i++) stim.push_back(VID_BW'($urandom));
        run_session(1'b1, 1'b1, 1'b0);

        // reset after 7 accepted IDs
        cap_addr.delete();
        cap_data.delete();
        pulse_start();
        stim.delete();
        for (int i = 0; i < 7; i++) stim.push_back(VID_BW'($urandom));
        drive_stream(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midfill_reset");
        @(negedge clk);
        rst_n = 1'b1;
        check("midfill_no_write", WW'(cap_addr.size()), WW'(0));
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(VID_BW'(16'h0C00 + i));
        run_session(1'b1, 1'b0, 1'b0);

        // reset while the write strobe is low releases it asynchronously
        pulse_start();
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(VID_BW'($urandom));
        drive_stream(1'b0, 1'b0, 1'b0);
        check("wsb_low_in_write", WW'(sram_wsb), WW'(0));
        #2 rst_n = 1'b0;
        #1 check_reset_values("write_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("after_write_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vid_sram_writer.md
Name: vid_sram_writer

Overview:
- Upstream stage of the vertex-ID SRAM (16 lanes x 16 b = 256 b per word, 32 words).
- Accepts a serial stream of vertex IDs over a valid/ready handshake and packs Q IDs into one VID_BW*Q-bit word.
- Issues one active-low write per packed word at sequential addresses from 0.
- Reports batch count, completion and overflow to the controller.

Parameters:
- ADDR_SPACE, 5, SRAM address width; capacity 2^ADDR_SPACE words.
- Q, 16, vertex IDs per SRAM word (lanes).
- VID_BW, 16, bits per vertex ID.
- PAD_VID, {VID_BW{1'b1}}, fill value for unused lanes of a partial last word.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a new fill session.
- in_valid  in  1  in_vid is valid.
- in_ready  out  1  block accepts in_vid this cycle.
- in_vid  in  VID_BW  vertex ID.
- in_last  in  1  marks the final ID of the stream; qualified by handshake.
- sram_wsb  out  1  SRAM write strobe, active low.
- sram_waddr  out  ADDR_SPACE  SRAM write address.
- sram_wdata  out  VID_BW*Q  packed word; lane i at bits [i*VID_BW +: VID_BW].
- batch_cnt  out  ADDR_SPACE+1  number of words written this session.
- done  out  1  session finished; held high until the next start.
- overflow  out  1  SRAM filled before in_last was seen; held until the next start.

Behaviour:
- Reset values (async, rst_n=0): state IDLE, in_ready=0, sram_wsb=1, sram_waddr=0, sram_wdata=all PAD_VID, batch_cnt=0, done=0, overflow=0, lane counter=0.
- All outputs are registered. in_ready is decoded from state only (high in FILL).
- States: IDLE, FILL, WRITE, DONE.
- IDLE or DONE, start=1 -> FILL.
  - Clears batch_cnt, sram_waddr, overflow, done and the lane counter.
  - Presets all lanes to PAD_VID.
- start is ignored in FILL and WRITE.
- FILL:
  - On each handshake (in_valid & in_ready), in_vid is stored in lane[lane_cnt] and lane_cnt increments.
  - If the accepted ID is lane Q-1 or has in_last=1, go to WRITE on the next cycle and latch a last flag.
  - in_valid gaps are allowed; lane state is held with no timeout.
- WRITE (exactly one cycle):
  - in_ready=0, sram_wsb=0, sram_waddr=current address, sram_wdata=packed lanes.
  - The SRAM captures on the rising edge that ends this cycle.
- After WRITE:
  - batch_cnt+1, address+1, lane_cnt=0, lanes preset to PAD_VID.
  - last flag set -> DONE.
  - Else if the write was at address 2^ADDR_SPACE-1 -> DONE with overflow=1.
  - Else -> FILL.
- Throughput: Q IDs per Q+1 cycles.
- Latency: accept of the Q-th ID at edge k -> sram_wsb low in cycle k..k+1 -> data in SRAM at edge k+1.
- Partial word: in_last on lane j<Q-1 writes lanes j+1..Q-1 as PAD_VID.
- in_last=1 with in_valid=0 has no effect.
- Address wrap: never occurs; the block stops at overflow. An in_last on the final word gives done=1, overflow=0.
- DONE: done=1, in_ready=0, sram_wsb=1. Stays in DONE until start.
- Reset mid-operation: immediate return to reset values. sram_wsb deasserts asynchronously. A partially packed word is discarded.
- sram_wdata holds its last value outside WRITE; only sram_wsb qualifies it.

Decomposition:
- Package vid_pkg holds:
  - constants VID_BW, Q, ADDR_SPACE, PAD_VID;
  - the state enum (IDLE, FILL, WRITE, DONE);
  - a lane-index width function (clog2 of Q).
- One natural sub-module: vid_lane_pack.
  - Owns the Q-lane register array, lane counter, load/preset controls and the packed-word output.
  - The top level keeps the FSM, address and batch counters, and flags.

Test Plan:
- start, then IDs 0..15 back-to-back with in_last on 15 -> one write, waddr=0, lane i=i, batch_cnt=1, done=1, overflow=0, in_ready low for exactly one cycle before DONE.
- IDs 16..35 (20 IDs), last on 35 -> waddr 0 gets lanes 16..31; waddr 1 gets lanes 0-3 = 32..35 and lanes 4-15 = 16'hFFFF; batch_cnt=2.
- Random in_valid gaps and start pulses during FILL and WRITE -> identical SRAM contents to the gap-free run; start ignored.
- 32*16 = 512 IDs, no in_last -> 32 writes at waddr 0..31, batch_cnt=32, overflow=1, done=1; ID 513 is never accepted (in_ready=0).
- Single ID 16'h00A5 with in_last -> one write, waddr=0, lane0=00A5, lanes 1-15 = FFFF.
- rst_n low after 7 accepted IDs -> sram_wsb=1 immediately and no write occurs. After release, start plus 16 IDs writes waddr 0 with only the new IDs.
